// File: rtl/correlation_accumulator.sv
// Window accumulator for correlation_cell products: sums I^2 and T[k]*I over WINDOW_PIXELS beats.
// Optional macro CORR_BEST_MATCH_EN adds best_idx (argmax of T_x_I_sum, ties to lowest index).
module correlation_accumulator #(
  parameter int PIXEL_SIZE    = 8,
  parameter int NUM_TEMPLATES = 10,
  parameter int WINDOW_PIXELS = 64,
  localparam int PW           = 2 * PIXEL_SIZE,
  localparam int ACC_W        = PW + $clog2(WINDOW_PIXELS)
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PW-1:0]                    I_square_in,
  input  logic [NUM_TEMPLATES*PW-1:0]      T_x_I_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 I_square_sum,
  output logic [NUM_TEMPLATES*ACC_W-1:0]   T_x_I_sum
`ifdef CORR_BEST_MATCH_EN
  ,
  output logic [$clog2(NUM_TEMPLATES)-1:0] best_idx
`endif
);

  localparam int CNT_W = $clog2(WINDOW_PIXELS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_PIXELS - 1);

  typedef enum logic {ACCUM, FULL} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc_isq;
  logic [ACC_W-1:0] acc_txi [NUM_TEMPLATES];
  logic [ACC_W-1:0] nxt_isq;
  logic [ACC_W-1:0] nxt_txi [NUM_TEMPLATES];
  logic             last_beat;
  logic             accept;
  logic             drain;

  // Only the closing beat of a window has to wait for a held result to drain.
  assign last_beat = (cnt == LAST);
  assign in_ready  = !(state == FULL && !out_ready && last_beat);
  assign accept    = in_valid && in_ready;
  assign drain     = (state == FULL) && out_ready;
  assign out_valid = (state == FULL);

  always_comb begin
    nxt_isq = acc_isq + ACC_W'(I_square_in);
    for (int unsigned k = 0; k < NUM_TEMPLATES; k++) begin
      nxt_txi[k] = acc_txi[k] + ACC_W'(T_x_I_in[k*PW +: PW]);
    end
  end

`ifdef CORR_BEST_MATCH_EN
  localparam int IDX_W = $clog2(NUM_TEMPLATES);

  logic [IDX_W-1:0] nxt_best;
  logic [ACC_W-1:0] best_val;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    nxt_best = '0;
    best_val = nxt_txi[0];
    for (int unsigned k = 1; k < NUM_TEMPLATES; k++) begin
      if (nxt_txi[k] > best_val) begin
        best_val = nxt_txi[k];
        nxt_best = IDX_W'(k);
      end
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ACCUM;
      cnt          <= '0;
      acc_isq      <= '0;
      I_square_sum <= '0;
      T_x_I_sum    <= '0;
      for (int unsigned k = 0; k < NUM_TEMPLATES; k++) begin
        acc_txi[k] <= '0;
      end
`ifdef CORR_BEST_MATCH_EN
      best_idx     <= '0;
`endif
    end else begin
      if (drain) begin
        state <= ACCUM;
      end
      // A window ending on the drain edge overrides the clear above.
      if (accept) begin
        if (last_beat) begin
          state        <= FULL;
          cnt          <= '0;
          acc_isq      <= '0;
          I_square_sum <= nxt_isq;
          for (int unsigned k = 0; k < NUM_TEMPLATES; k++) begin
            acc_txi[k]                   <= '0;
            T_x_I_sum[k*ACC_W +: ACC_W]  <= nxt_txi[k];
          end
`ifdef CORR_BEST_MATCH_EN
          best_idx     <= nxt_best;
`endif
        end else begin
          cnt     <= cnt + 1'b1;
          acc_isq <= nxt_isq;
          for (int unsigned k = 0; k < NUM_TEMPLATES; k++) begin
            acc_txi[k] <= nxt_txi[k];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_correlation_accumulator.sv
// Self-checking bench for correlation_accumulator (PIXEL_SIZE=8, NUM_TEMPLATES=2, WINDOW_PIXELS=4).
// Build with CORR_BEST_MATCH_EN defined to also cover best_idx.
module tb_correlation_accumulator;

  localparam int PW = 16;
  localparam int AW = 18;
  localparam int NT = 2;
  localparam int WP = 4;

  typedef logic [PW-1:0] win_t [WP];

  logic            CLK;
  logic            RST_N;
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   I_square_in;
  logic [NT*PW-1:0] T_x_I_in;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   I_square_sum;
  logic [NT*AW-1:0] T_x_I_sum;
`ifdef CORR_BEST_MATCH_EN
  logic            best_idx;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  correlation_accumulator #(
    .PIXEL_SIZE(8),
    .NUM_TEMPLATES(NT),
    .WINDOW_PIXELS(WP)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .I_square_in(I_square_in),
    .T_x_I_in(T_x_I_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .I_square_sum(I_square_sum),
    .T_x_I_sum(T_x_I_sum)
`ifdef CORR_BEST_MATCH_EN
    ,
    .best_idx(best_idx)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // T_x_I_in packs template 0 in the low bits.
  task automatic beat(input logic [PW-1:0] isq, input logic [PW-1:0] t0, input logic [PW-1:0] t1);
    I_square_in = isq;
    T_x_I_in    = {t1, t0};
    in_valid    = 1'b1;
  endtask

  function automatic logic [AW-1:0] wsum(input win_t v);
    logic [AW-1:0] s;
    s = '0;
    for (int i = 0; i < WP; i++) s = s + AW'(v[i]);
    return s;
  endfunction

  function automatic win_t rand_win();
    win_t v;
    for (int i = 0; i < WP; i++) v[i] = PW'($urandom_range(0, 65025));
    return v;
  endfunction

  task automatic test_reset();
    RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    I_square_in = '0; T_x_I_in = '0;
    #12;
    n_cmp++;
    if ({out_valid, I_square_sum, T_x_I_sum} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected 0", {out_valid, I_square_sum, T_x_I_sum});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
`ifdef CORR_BEST_MATCH_EN
    n_cmp++;
    if (best_idx !== 1'b0) begin
      n_bad++; $display("FAIL reset_best_idx: got %b expected 0", best_idx);
    end
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    for (int i = 0; i < WP; i++) begin
      beat(PW'(i + 1), 16'd10, 16'd5);
      tick();
      n_cmp++;
      if (out_valid !== (i == WP - 1)) begin
        n_bad++; $display("FAIL basic_valid_beat%0d: got %b expected %b", i, out_valid, (i == WP - 1));
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({I_square_sum, T_x_I_sum} !== {18'd10, 18'd20, 18'd40}) begin
      n_bad++; $display("FAIL basic_sums: got %h expected %h", {I_square_sum, T_x_I_sum}, {18'd10, 18'd20, 18'd40});
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_valid_pulse: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_max_values();
    out_ready = 1'b1;
    for (int i = 0; i < WP; i++) begin
      in_valid = 1'b0;
      if (i > 0) repeat ($urandom_range(0, 2)) tick();
      beat(16'd65025, 16'd65025, 16'd65025);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, I_square_sum, T_x_I_sum} !== {1'b1, 18'd260100, 18'd260100, 18'd260100}) begin
      n_bad++; $display("FAIL max_sums: got %h expected %h", {out_valid, I_square_sum, T_x_I_sum},
                        {1'b1, 18'd260100, 18'd260100, 18'd260100});
    end
    tick();
  endtask

  task automatic test_backpressure();
    win_t ai, a0, a1, bi, b0, b1;
    logic [3*AW:0] exp1, exp2;
    ai = rand_win(); a0 = rand_win(); a1 = rand_win();
    bi = rand_win(); b0 = rand_win(); b1 = rand_win();
    exp1 = {1'b1, wsum(ai), wsum(a1), wsum(a0)};
    exp2 = {1'b1, wsum(bi), wsum(b1), wsum(b0)};
    out_ready = 1'b1;
    for (int i = 0; i < WP; i++) begin beat(ai[i], a0[i], a1[i]); tick(); end
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < WP - 1; i++) begin
      beat(bi[i], b0[i], b1[i]);
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++; $display("FAIL bp_early_ready%0d: got %b expected 1", i, in_ready);
      end
      tick();
    end
    beat(bi[WP-1], b0[WP-1], b1[WP-1]);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_stall%0d: got %b expected 0", c, in_ready);
      end
      n_cmp++;
      if ({out_valid, I_square_sum, T_x_I_sum} !== exp1) begin
        n_bad++; $display("FAIL bp_hold%0d: got %h expected %h", c, {out_valid, I_square_sum, T_x_I_sum}, exp1);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, I_square_sum, T_x_I_sum} !== exp2) begin
      n_bad++; $display("FAIL bp_window2: got %h expected %h", {out_valid, I_square_sum, T_x_I_sum}, exp2);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    win_t ai, a0, a1, bi, b0, b1, ci, c0, c1;
    logic [3*AW:0] exp_b, exp_c;
    ai = rand_win(); a0 = rand_win(); a1 = rand_win();
    bi = rand_win(); b0 = rand_win(); b1 = rand_win();
    ci = rand_win(); c0 = rand_win(); c1 = rand_win();
    exp_b = {1'b1, wsum(bi), wsum(b1), wsum(b0)};
    exp_c = {1'b1, wsum(ci), wsum(c1), wsum(c0)};
    out_ready = 1'b1;
    for (int i = 0; i < WP; i++) begin beat(ai[i], a0[i], a1[i]); tick(); end
    out_ready = 1'b0;
    for (int i = 0; i < WP - 1; i++) begin beat(bi[i], b0[i], b1[i]); tick(); end
    beat(bi[WP-1], b0[WP-1], b1[WP-1]);
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready: got %b expected 1", in_ready);
    end
    tick();
    n_cmp++;
    if ({out_valid, I_square_sum, T_x_I_sum} !== exp_b) begin
      n_bad++; $display("FAIL b2b_no_gap: got %h expected %h", {out_valid, I_square_sum, T_x_I_sum}, exp_b);
    end
    for (int i = 0; i < WP; i++) begin
      beat(ci[i], c0[i], c1[i]);
      tick();
      n_cmp++;
      if (out_valid !== (i == WP - 1)) begin
        n_bad++; $display("FAIL b2b_c_valid%0d: got %b expected %b", i, out_valid, (i == WP - 1));
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, I_square_sum, T_x_I_sum} !== exp_c) begin
      n_bad++; $display("FAIL b2b_window_c: got %h expected %h", {out_valid, I_square_sum, T_x_I_sum}, exp_c);
    end
    tick();
  endtask

`ifdef CORR_BEST_MATCH_EN
  task automatic test_best_match();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < WP; i++) begin
        case (c)
          0:       beat(16'd1, 16'd10, 16'd10);
          1:       beat(16'd1, 16'd5, (i < 2) ? 16'd12 : 16'd13);
          default: beat(16'd1, (i < 2) ? 16'd13 : 16'd12, 16'd5);
        endcase
        tick();
      end
      in_valid = 1'b0;
      n_cmp++;
      if (best_idx !== (c == 1)) begin
        n_bad++; $display("FAIL best_case%0d: got %b expected %b", c, best_idx, (c == 1));
      end
      tick();
    end
  endtask
`endif

  task automatic test_mid_reset();
    win_t ai, a0, a1;
    ai = rand_win(); a0 = rand_win(); a1 = rand_win();
    out_ready = 1'b0;
    for (int i = 0; i < WP; i++) begin beat(ai[i], a0[i], a1[i]); tick(); end
    for (int i = 0; i < 2; i++) begin beat(16'd1, 16'd1, 16'd1); tick(); end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL mr_held_before: got %b expected 1", out_valid);
    end
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, I_square_sum, T_x_I_sum} !== '0) begin
      n_bad++; $display("FAIL mr_async_clear: got %h expected 0", {out_valid, I_square_sum, T_x_I_sum});
    end
`ifdef CORR_BEST_MATCH_EN
    n_cmp++;
    if (best_idx !== 1'b0) begin
      n_bad++; $display("FAIL mr_best_clear: got %b expected 0", best_idx);
    end
`endif
    @(negedge CLK);
    RST_N = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < WP; i++) begin beat(16'd1, 16'd1, 16'd1); tick(); end
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, I_square_sum, T_x_I_sum} !== {1'b1, 18'd4, 18'd4, 18'd4}) begin
      n_bad++; $display("FAIL mr_fresh_window: got %h expected %h", {out_valid, I_square_sum, T_x_I_sum},
                        {1'b1, 18'd4, 18'd4, 18'd4});
    end
    tick();
  endtask

  // Reference: completed windows queue up in order; the head is what the output must show.
  task automatic test_random();
    logic [3*AW-1:0] q[$];
    logic [3*AW-1:0] head;
    logic [AW-1:0]   s_i, s_0, s_1;
    logic [PW-1:0]   di, d0, d1;
    int              n;
    logic            exp_valid, exp_ready, acc, hs;
    s_i = '0; s_0 = '0; s_1 = '0; n = 0;
    for (int c = 0; c < 3000; c++) begin
      di = ($urandom_range(0, 7) == 0) ? PW'(65025) : PW'($urandom_range(0, 65025));
      d0 = PW'($urandom_range(0, 65025));
      d1 = PW'($urandom_range(0, 65025));
      if ($urandom_range(0, 5) == 0) d1 = d0;
      I_square_in = di;
      T_x_I_in    = {d1, d0};
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      #1;
      exp_valid = (q.size() != 0);
      exp_ready = !(exp_valid && !out_ready && n == WP - 1);
      n_cmp++;
      if (out_valid !== exp_valid) begin
        n_bad++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, out_valid, exp_valid);
      end
      n_cmp++;
      if (in_ready !== exp_ready) begin
        n_bad++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, in_ready, exp_ready);
      end
      if (exp_valid) begin
        head = q[0];
        n_cmp++;
        if ({I_square_sum, T_x_I_sum} !== head) begin
          n_bad++; $display("FAIL rnd_sums@%0d: got %h expected %h", c, {I_square_sum, T_x_I_sum}, head);
        end
`ifdef CORR_BEST_MATCH_EN
        n_cmp++;
        if (best_idx !== (head[2*AW-1:AW] > head[AW-1:0])) begin
          n_bad++; $display("FAIL rnd_best@%0d: got %b expected %b", c, best_idx, (head[2*AW-1:AW] > head[AW-1:0]));
        end
`endif
      end
      acc = in_valid && exp_ready;
      hs  = exp_valid && out_ready;
      tick();
      if (hs) void'(q.pop_front());
      if (acc) begin
        s_i = s_i + AW'(di);
        s_0 = s_0 + AW'(d0);
        s_1 = s_1 + AW'(d1);
        n++;
        if (n == WP) begin
          q.push_back({s_i, s_1, s_0});
          s_i = '0; s_0 = '0; s_1 = '0; n = 0;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_values();
    test_backpressure();
    test_back_to_back();
`ifdef CORR_BEST_MATCH_EN
    test_best_match();
`endif
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
